bmc_rx_controller: RTL and testbench

Frame sequencer for the optical link receive path. It hunts the incoming half-bit stream for a sync preamble and clears the BMC decoder at each frame start. It then gates exactly 56 half-bits into the decoder while checking biphase-mark legality, and captures the decoded 28-bit block into a valid/ready output register. It sits between the line sampler (one half-bit per transfer) and the downstream block consumer, and owns `bmc_decoder`'s `rst`/`valid_in`/`i_block` pins.

---
 rtl/bmc_rx_controller.sv | 154 +++++++++++++++
 tb/tb_bmc_rx_controller.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmc_rx_controller.sv
// Receive-path frame sequencer: hunts for the sync preamble, clears and feeds the BMC decoder,
// checks biphase-mark legality and captures each decoded block into a valid/ready register.
module bmc_rx_controller #(
  parameter logic [7:0]  SYNC_WORD = 8'hE8,
  parameter int unsigned HALF_BITS = 56,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        dec_clear,
  output logic        dec_valid,
  output logic        dec_bit,
  input  logic [27:0] dec_block,
  output logic        o_valid,
  output logic [27:0] o_block,
  input  logic        o_ready,
  output logic        bmc_err,
  output logic        timeout_err,
  output logic [7:0]  drop_count
);

  localparam int unsigned CntW  = $clog2(HALF_BITS);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StHunt, StClear, StRecv, StCapture} state_e;

  state_e            state_q, state_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              prev_q, prev_d;
  logic [27:0]       o_block_q, o_block_d;
  logic              o_valid_q, o_valid_d;
  logic              bmc_err_q, bmc_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        drop_q, drop_d;

  logic       transfer;
  logic       abort;
  logic       bmc_bad;
  logic       last_idx;
  logic       capture_fire;
  logic [7:0] shreg_new;

  assign in_ready     = (state_q == StHunt) || (state_q == StRecv);
  assign transfer     = in_valid && in_ready;
  assign dec_valid    = in_valid && (state_q == StRecv);
  assign dec_bit      = in_bit;
  assign dec_clear    = (state_q == StClear);
  assign shreg_new    = {shreg_q[6:0], in_bit};
  // Even half-bits open a data bit and must toggle the line level.
  assign bmc_bad      = !cnt_q[0] && (in_bit == prev_q);
  assign last_idx     = (cnt_q == CntW'(HALF_BITS - 1));
  assign capture_fire = (state_q == StCapture) && (!o_valid_q || o_ready);

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    prev_d        = prev_q;
    bmc_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    abort         = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (transfer) begin
          shreg_d = shreg_new;
          if (shreg_new == SYNC_WORD) state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = '0;
        prev_d  = SYNC_WORD[0];
        state_d = StRecv;
      end
      StRecv: begin
        if (transfer) begin
          idle_d = '0;
          prev_d = in_bit;
          cnt_d  = cnt_q + CntW'(1);
          if (bmc_bad) begin
            bmc_err_d = 1'b1;
            abort     = 1'b1;
            state_d   = StHunt;
          end else if (last_idx) begin
            state_d = StCapture;
          end
        end else if (idle_q == IdleW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          abort         = 1'b1;
          state_d       = StHunt;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
      end
      StCapture: begin
        if (capture_fire) state_d = StHunt;
      end
      default: state_d = StHunt;
    endcase

    // Every return to HUNT demands a complete fresh preamble.
    if (state_d == StHunt && state_q != StHunt) begin
      shreg_d = '0;
      idle_d  = '0;
    end
  end

  always_comb begin
    drop_d    = (abort && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    o_block_d = capture_fire ? dec_block : o_block_q;
    if (capture_fire)  o_valid_d = 1'b1;
    else if (o_ready)  o_valid_d = 1'b0;
    else               o_valid_d = o_valid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StHunt;
      shreg_q       <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      prev_q        <= 1'b0;
      o_block_q     <= '0;
      o_valid_q     <= 1'b0;
      bmc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      prev_q        <= prev_d;
      o_block_q     <= o_block_d;
      o_valid_q     <= o_valid_d;
      bmc_err_q     <= bmc_err_d;
      timeout_err_q <= timeout_err_d;
      drop_q        <= drop_d;
    end
  end

  assign o_valid     = o_valid_q;
  assign o_block     = o_block_q;
  assign bmc_err     = bmc_err_q;
  assign timeout_err = timeout_err_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_bmc_rx_controller.sv
// Bench for bmc_rx_controller: a stub BMC decoder, frame encoder and a scoreboard of expected
// blocks drive directed scenarios and randomized frames with random gaps and back-pressure.
module tb_bmc_rx_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        in_ready;
  logic        dec_clear;
  logic        dec_valid;
  logic        dec_bit;
  logic [27:0] dec_block;
  logic        o_valid;
  logic [27:0] o_block;
  logic        o_ready;
  logic        bmc_err;
  logic        timeout_err;
  logic [7:0]  drop_count;

  logic        o_ready_drv = 1'b1;
  logic        rand_mode = 1'b0;
  logic        rand_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int aborts = 0;

  bmc_rx_controller dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .dec_clear  (dec_clear),
    .dec_valid  (dec_valid),
    .dec_bit    (dec_bit),
    .dec_block  (dec_block),
    .o_valid    (o_valid),
    .o_block    (o_block),
    .o_ready    (o_ready),
    .bmc_err    (bmc_err),
    .timeout_err(timeout_err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  assign o_ready = rand_mode ? rand_ready : o_ready_drv;
  always @(negedge clk) rand_ready <= 1'($urandom_range(0, 1));

  // Stub decoder: each pair of half-bits yields one data bit (1 when the halves differ).
  logic [27:0] blk_q;
  logic        h0_q, have_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q <= '0; h0_q <= 1'b0; have_q <= 1'b0;
    end else if (dec_clear) begin
      blk_q <= '0; h0_q <= 1'b0; have_q <= 1'b0;
    end else if (dec_valid) begin
      if (!have_q) begin
        h0_q <= dec_bit; have_q <= 1'b1;
      end else begin
        blk_q <= {blk_q[26:0], h0_q ^ dec_bit}; have_q <= 1'b0;
      end
    end
  end
  assign dec_block = blk_q;

  int          cyc = 0;
  int          n_clear = 0, n_dvalid = 0, n_bmc = 0, n_tmo = 0;
  int          clear_cyc[$];
  logic [27:0] got_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (o_valid && o_ready) got_q.push_back(o_block);
      if (dec_clear) begin
        n_clear <= n_clear + 1;
        clear_cyc.push_back(cyc);
      end
      if (dec_valid) n_dvalid <= n_dvalid + 1;
      if (bmc_err) n_bmc <= n_bmc + 1;
      if (timeout_err) n_tmo <= n_tmo + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int exp_drop();
    return (aborts > 255) ? 255 : aborts;
  endfunction

  // Biphase-mark: level toggles at every bit boundary and again mid-bit for a one.
  function automatic logic [55:0] encode(input logic [27:0] d);
    logic [55:0] h;
    logic        lvl;
    lvl = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      lvl = ~lvl;
      h[2*i+1] = lvl;
      if (d[i]) lvl = ~lvl;
      h[2*i] = lvl;
    end
    return h;
  endfunction

  task automatic send_half(input logic b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      miscompares++;
      $display("FAIL send_half: in_ready stuck at %0b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_preamble();
    logic [7:0] sw;
    sw = 8'hE8;
    for (int i = 7; i >= 0; i--) send_half(sw[i]);
  endtask

  task automatic send_frame(input logic [27:0] d, input int gap_max);
    logic [55:0] h;
    h = encode(d);
    send_preamble();
    for (int i = 55; i >= 0; i--) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_half(h[i]);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    o_ready_drv = 1'b1;
    in_valid = 1'b0;
    while ((o_valid || !in_ready) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_bit = 1'b1; o_ready_drv = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid: got %0b want 0", o_valid); end
    vectors++; if (dec_clear !== 1'b0) begin miscompares++; $display("FAIL reset_dec_clear: got %0b want 0", dec_clear); end
    vectors++; if (dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dec_valid: got %0b want 0", dec_valid); end
    vectors++; if ({bmc_err, timeout_err} !== 2'b00) begin miscompares++; $display("FAIL reset_errs: got %b want 00", {bmc_err, timeout_err}); end
    vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    vectors++; if (o_block !== 28'd0) begin miscompares++; $display("FAIL reset_o_block: got %h want 0", o_block); end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    int c0, v0;
    got_q.delete();
    c0 = n_clear; v0 = n_dvalid;
    o_ready_drv = 1'b1;
    send_frame(28'h0000000, 0);
    vectors++; if (o_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL zero_capture_cycle: o_valid=%0b in_ready=%0b want 0 0", o_valid, in_ready); end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("FAIL zero_o_valid: got %0b want 1", o_valid); end
    vectors++; if (o_block !== 28'h0000000) begin miscompares++; $display("FAIL zero_o_block: got %h want 0000000", o_block); end
    @(negedge clk);
    vectors++; if (n_clear - c0 != 1) begin miscompares++; $display("FAIL zero_dec_clear: got %0d pulses want 1", n_clear - c0); end
    vectors++; if (n_dvalid - v0 != 56) begin miscompares++; $display("FAIL zero_dec_valid: got %0d pulses want 56", n_dvalid - v0); end
    vectors++; if (drop_count !== 8'd0) begin miscompares++; $display("FAIL zero_drop: got %0d want 0", drop_count); end
    vectors++; if (got_q.size() != 1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL zero_delivered: got %0d blocks o_valid=%0b want 1 0", got_q.size(), o_valid); end
  endtask

  task automatic test_back_to_back();
    int cl0;
    got_q.delete();
    cl0 = clear_cyc.size();
    send_frame(28'hFFFFFFF, 0);
    send_frame(28'hA5A5A5A, 0);
    drain();
    vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    else begin
      vectors++; if (got_q[0] !== 28'hFFFFFFF) begin miscompares++; $display("FAIL b2b_first: got %h want FFFFFFF", got_q[0]); end
      vectors++; if (got_q[1] !== 28'hA5A5A5A) begin miscompares++; $display("FAIL b2b_second: got %h want A5A5A5A", got_q[1]); end
    end
    vectors++;
    if (clear_cyc.size() < cl0 + 2) begin miscompares++; $display("FAIL b2b_period: got %0d clears want 2", clear_cyc.size() - cl0); end
    else if (clear_cyc[cl0+1] - clear_cyc[cl0] != 66) begin
      miscompares++; $display("FAIL b2b_period: got %0d cycles want 66", clear_cyc[cl0+1] - clear_cyc[cl0]);
    end
  endtask

  task automatic test_bmc_violation();
    int b0;
    logic [27:0] d;
    got_q.delete();
    b0 = n_bmc;
    send_preamble();
    send_half(1'b1); send_half(1'b0); send_half(1'b0);
    aborts++;
    vectors++; if (bmc_err !== 1'b1) begin miscompares++; $display("FAIL bmc_pulse: got %0b want 1", bmc_err); end
    send_half(1'b1);
    vectors++; if (bmc_err !== 1'b0) begin miscompares++; $display("FAIL bmc_pulse_width: got %0b want 0", bmc_err); end
    idle(3);
    vectors++; if (n_bmc - b0 != 1) begin miscompares++; $display("FAIL bmc_count: got %0d want 1", n_bmc - b0); end
    vectors++; if (drop_count !== 8'(exp_drop())) begin miscompares++; $display("FAIL bmc_drop: got %0d want %0d", drop_count, exp_drop()); end
    vectors++; if (got_q.size() != 0 || o_valid !== 1'b0) begin miscompares++; $display("FAIL bmc_no_output: got %0d blocks want 0", got_q.size()); end
    d = 28'($urandom);
    send_frame(d, 0);
    drain();
    vectors++; if (got_q.size() != 1 || got_q[0] !== d) begin miscompares++; $display("FAIL bmc_recover: got %0d blocks want 1 of %h", got_q.size(), d); end
  endtask

  task automatic one_timeout(input int iter);
    logic [55:0] h;
    int k;
    h = encode(28'($urandom));
    send_preamble();
    for (int i = 55; i >= 46; i--) send_half(h[i]);
    in_valid = 1'b0;
    k = 0;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (timeout_err) break;
    end
    aborts++;
    vectors++; if (k != 255) begin miscompares++; $display("FAIL timeout_delay[%0d]: got %0d cycles want 255", iter, k); end
    @(negedge clk);
    vectors++; if (timeout_err !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL timeout_pulse[%0d]: err=%0b in_ready=%0b want 0 1", iter, timeout_err, in_ready); end
    vectors++; if (drop_count !== 8'(exp_drop())) begin miscompares++; $display("FAIL timeout_drop[%0d]: got %0d want %0d", iter, drop_count, exp_drop()); end
  endtask

  task automatic test_timeout_saturation();
    for (int t = 0; t < 3; t++) one_timeout(t);
    while (aborts < 300) begin
      send_preamble();
      send_half(1'b1); send_half(1'b0); send_half(1'b0);
      aborts++;
    end
    idle(2);
    vectors++; if (drop_count !== 8'd255) begin miscompares++; $display("FAIL drop_saturate: got %0d want 255", drop_count); end
    one_timeout(3);
  endtask

  task automatic test_backpressure();
    logic [27:0] a, b;
    a = 28'($urandom); b = 28'($urandom);
    got_q.delete();
    o_ready_drv = 1'b0;
    send_frame(a, 0);
    idle(2);
    vectors++; if (o_valid !== 1'b1 || o_block !== a) begin miscompares++; $display("FAIL bp_first_held: valid=%0b block=%h want 1 %h", o_valid, o_block, a); end
    send_frame(b, 1);
    in_valid = 1'b1; in_bit = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (in_ready !== 1'b0 || dec_valid !== 1'b0) begin miscompares++; $display("FAIL bp_stall: in_ready=%0b dec_valid=%0b want 0 0", in_ready, dec_valid); end
    vectors++; if (o_block !== a || got_q.size() != 0) begin miscompares++; $display("FAIL bp_hold: block=%h n=%0d want %h 0", o_block, got_q.size(), a); end
    in_valid = 1'b0;
    o_ready_drv = 1'b1;
    @(negedge clk);
    o_ready_drv = 1'b0;
    vectors++; if (got_q.size() != 1 || got_q[0] !== a) begin miscompares++; $display("FAIL bp_first_out: n=%0d want 1 of %h", got_q.size(), a); end
    vectors++; if (o_valid !== 1'b1 || o_block !== b || in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_reload: valid=%0b block=%h ready=%0b want 1 %h 1", o_valid, o_block, in_ready, b); end
    drain();
    vectors++; if (got_q.size() != 2 || got_q[1] !== b) begin miscompares++; $display("FAIL bp_second_out: n=%0d want 2 ending %h", got_q.size(), b); end
  endtask

  task automatic test_reset_mid_frame();
    logic [55:0] h;
    logic [27:0] d;
    int b0, t0;
    got_q.delete();
    h = encode(28'($urandom));
    send_preamble();
    for (int i = 55; i >= 36; i--) send_half(h[i]);
    b0 = n_bmc; t0 = n_tmo;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1 || o_valid !== 1'b0 || dec_clear !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl: ready=%0b valid=%0b clr=%0b want 1 0 0", in_ready, o_valid, dec_clear); end
    vectors++; if (drop_count !== 8'd0 || o_block !== 28'd0) begin miscompares++; $display("FAIL rstmid_regs: drop=%0d block=%h want 0 0", drop_count, o_block); end
    vectors++; if ({bmc_err, timeout_err} !== 2'b00) begin miscompares++; $display("FAIL rstmid_errs: got %b want 00", {bmc_err, timeout_err}); end
    rst = 1'b1;
    aborts = 0;
    idle(300);
    vectors++; if (n_bmc != b0 || n_tmo != t0) begin miscompares++; $display("FAIL rstmid_no_pulse: bmc+%0d tmo+%0d want 0 0", n_bmc - b0, n_tmo - t0); end
    d = 28'($urandom);
    send_frame(d, 0);
    drain();
    vectors++; if (got_q.size() != 1 || got_q[0] !== d) begin miscompares++; $display("FAIL rstmid_recover: n=%0d want 1 of %h", got_q.size(), d); end
  endtask

  task automatic test_random();
    logic [27:0] exp_q[$];
    logic [27:0] d;
    got_q.delete();
    rand_mode = 1'b1;
    for (int f = 0; f < 20; f++) begin
      d = 28'($urandom);
      exp_q.push_back(d);
      for (int z = $urandom_range(0, 4); z > 0; z--) send_half(1'b0);
      send_frame(d, 3);
    end
    rand_mode = 1'b0;
    drain();
    vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_block[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    vectors++; if (drop_count !== 8'(exp_drop())) begin miscompares++; $display("FAIL rand_drop: got %0d want %0d", drop_count, exp_drop()); end
  endtask

  initial begin
    in_valid = 1'b0;
    in_bit = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_all_zero();
    test_back_to_back();
    test_bmc_violation();
    test_timeout_saturation();
    test_reset_mid_frame();
    test_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
